misr_bist_ctrl: RTL and testbench

BIST sequencer for the 7-bit NOR-feedback MISR signature compactor. It flushes the MISR into a known all-zero state and drives an LFSR pattern stream onto the MISR's three serial inputs for a programmed number of cycles. It then waits for the signature to settle, compares it against a golden value and reports pass or fail. It sits between the test-mode top level and the MISR instance. The MISR has no reset of its own, so this block is its only initialiser.

---
 rtl/misr_bist_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_misr_bist_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/misr_bist_ctrl.sv
// -----------------------------------------------------------------------------
// misr_bist_ctrl
//
// BIST sequencer for the 7-bit NOR-feedback MISR signature compactor. The MISR
// has no reset of its own, so this block is its only initialiser:
//   1. FLUSH: drive e2/e1/e0 = 111 for FLUSH_CYCLES cycles. Forcing all three
//      serial inputs high clears h4..h6 on the first edge, and the zeros then
//      shift down through h0..h3, leaving the MISR all-zero.
//   2. RUN: drive the low three bits of an 8-bit LFSR onto e0/e1/e2 for
//      N_PATTERNS cycles, stepping the LFSR every cycle.
//   3. DRAIN: one idle cycle (e=000) to cover the MISR's output register.
//   4. CMP: capture the MISR hf output into `signature` and compare it with
//      GOLDEN.
//   5. DONE: hold the result until the next start.
//
// Optional feature, enabled by defining MISR_BIST_ABORT_EN:
//   adds an `abort` input that drops any busy state back to IDLE.
//
// Handshake: `start` is a level sampled on the rising CLK edge only in IDLE or
// DONE; while busy it is ignored (no queueing). `done` acts as the result
// valid: `pass` and `signature` are meaningful whenever `done` is high, and
// stay stable until the edge that accepts the next `start`.
//
// Parameters:
//   N_PATTERNS   number of compaction cycles, 1..65535
//   GOLDEN       expected signature, same bit order as MISR hf
//   FLUSH_CYCLES cycles of e=111 to flush the MISR, >= 6
//   LFSR_SEED    non-zero seed of the pattern LFSR
//
// Ports:
//   CLK        clock, rising edge
//   RST_N      asynchronous active-low reset
//   start      begin a test (sampled in IDLE/DONE)
//   abort      (MISR_BIST_ABORT_EN only) cancel a running test
//   sig[6:0]   MISR hf output
//   e0,e1,e2   MISR serial inputs (registered)
//   busy       high in FLUSH, RUN, DRAIN, CMP (registered)
//   done       high in DONE (registered)
//   pass       registered compare result, valid while done
//   signature  captured sig value, valid while done
//   dbg_state  current FSM state, for observation only
// -----------------------------------------------------------------------------
module misr_bist_ctrl #(
  parameter int unsigned N_PATTERNS   = 64,
  parameter logic [6:0]  GOLDEN       = 7'h00,
  parameter int unsigned FLUSH_CYCLES = 6,
  parameter logic [7:0]  LFSR_SEED    = 8'h01
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       start,
`ifdef MISR_BIST_ABORT_EN
  input  logic       abort,
`endif
  input  logic [6:0] sig,
  output logic       e0,
  output logic       e1,
  output logic       e2,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [6:0] signature,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FLUSH = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_CMP   = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  // Terminal counts for the shared 16-bit cycle counter.
  localparam logic [15:0] FLUSH_LAST = 16'(FLUSH_CYCLES - 1);
  localparam logic [15:0] RUN_LAST   = 16'(N_PATTERNS - 1);

  state_t      state;
  logic [15:0] cnt;
  logic [7:0]  lfsr;
  logic [7:0]  lfsr_step;
  logic [2:0]  e_reg;   // {e2, e1, e0}

  // Taps at bits 7,5,4,3.
  assign lfsr_step = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};

  assign e0        = e_reg[0];
  assign e1        = e_reg[1];
  assign e2        = e_reg[2];
  assign dbg_state = state;

  // The e outputs are registered, so the value driven during a cycle is loaded
  // on the edge that enters it. During RUN the lfsr register therefore runs
  // one step ahead of the pattern currently on e: at RUN entry e gets the seed
  // bits and lfsr gets the first stepped value.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      lfsr      <= LFSR_SEED;
      e_reg     <= 3'b000;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      signature <= 7'h00;
    end else begin
      unique case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state <= ST_FLUSH;
            cnt   <= '0;
            lfsr  <= LFSR_SEED;
            e_reg <= 3'b111;
            busy  <= 1'b1;
            done  <= 1'b0;
            pass  <= 1'b0;
            // signature deliberately keeps the previous result until CMP.
          end
        end

        ST_FLUSH: begin
          if (cnt == FLUSH_LAST) begin
            state <= ST_RUN;
            cnt   <= '0;
            e_reg <= lfsr[2:0];
            lfsr  <= lfsr_step;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        ST_RUN: begin
          lfsr <= lfsr_step;
          if (cnt == RUN_LAST) begin
            state <= ST_DRAIN;
            cnt   <= '0;
            e_reg <= 3'b000;
          end else begin
            cnt   <= cnt + 16'd1;
            e_reg <= lfsr[2:0];
          end
        end

        ST_DRAIN: begin
          state <= ST_CMP;
        end

        ST_CMP: begin
          // sig now holds the MISR state after the last RUN pattern.
          state     <= ST_DONE;
          signature <= sig;
          pass      <= (sig == GOLDEN);
          busy      <= 1'b0;
          done      <= 1'b1;
        end

        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
          e_reg <= 3'b000;
          busy  <= 1'b0;
          done  <= 1'b0;
          pass  <= 1'b0;
        end
      endcase

`ifdef MISR_BIST_ABORT_EN
      // Placed after the case so it overrides any same-cycle transition.
      // busy is high exactly in FLUSH/RUN/DRAIN/CMP.
      if (abort && busy) begin
        state <= ST_IDLE;
        cnt   <= '0;
        lfsr  <= LFSR_SEED;
        e_reg <= 3'b000;
        busy  <= 1'b0;
        done  <= 1'b0;
        pass  <= 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_misr_bist_ctrl.sv
// -----------------------------------------------------------------------------
// tb_misr_bist_ctrl
//
// Two sequencer instances share one clock and reset:
//   A: N_PATTERNS=4, FLUSH_CYCLES=6, seed 8'h01
//   B: N_PATTERNS=1, FLUSH_CYCLES=6, seed 8'h01
// Each instance drives its own behavioural 7-bit NOR-feedback MISR (no reset,
// output register stage). Expected e streams, result words and done cycles are
// computed from the sequencing rules and pushed to queues when a start is
// issued; a negedge monitor pops and compares them.
// -----------------------------------------------------------------------------
module tb_misr_bist_ctrl;

  localparam int         F_A    = 6;
  localparam int         N_A    = 4;
  localparam logic [7:0] SEED_A = 8'h01;
  localparam logic [6:0] GOLD_A = 7'h78;
  localparam int         F_B    = 6;
  localparam int         N_B    = 1;
  localparam logic [7:0] SEED_B = 8'h01;
  localparam logic [6:0] GOLD_B = 7'h60;

  // ---------------- clock / reset ----------------
  logic CLK   = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic       start_a = 1'b0, start_b = 1'b0;
  logic       abort_a = 1'b0, abort_b = 1'b0;
  logic [6:0] sig_a, sig_b;
  logic       e0_a, e1_a, e2_a, busy_a, done_a, pass_a;
  logic       e0_b, e1_b, e2_b, busy_b, done_b, pass_b;
  logic [6:0] signature_a, signature_b;
  logic [2:0] dbg_a, dbg_b;

  misr_bist_ctrl #(.N_PATTERNS(N_A), .GOLDEN(GOLD_A), .FLUSH_CYCLES(F_A), .LFSR_SEED(SEED_A)) u_dut_a (
    .CLK(CLK), .RST_N(RST_N), .start(start_a),
`ifdef MISR_BIST_ABORT_EN
    .abort(abort_a),
`endif
    .sig(sig_a), .e0(e0_a), .e1(e1_a), .e2(e2_a), .busy(busy_a), .done(done_a),
    .pass(pass_a), .signature(signature_a), .dbg_state(dbg_a)
  );

  misr_bist_ctrl #(.N_PATTERNS(N_B), .GOLDEN(GOLD_B), .FLUSH_CYCLES(F_B), .LFSR_SEED(SEED_B)) u_dut_b (
    .CLK(CLK), .RST_N(RST_N), .start(start_b),
`ifdef MISR_BIST_ABORT_EN
    .abort(abort_b),
`endif
    .sig(sig_b), .e0(e0_b), .e1(e1_b), .e2(e2_b), .busy(busy_b), .done(done_b),
    .pass(pass_b), .signature(signature_b), .dbg_state(dbg_b)
  );

  // ---------------- behavioural MISR ----------------
  // e = {e2,e1,e0}. Inputs high force h6..h4 to 0; h3..h0 shift down.
  function automatic logic [6:0] misr_next(input logic [6:0] h, input logic [2:0] e);
    logic [6:0] n;
    n[6]   = ~(e[2] | h[0]);
    n[5]   = ~(e[1] | h[6]);
    n[4]   = ~(e[0] | h[5]);
    n[3:0] = h[4:1];
    return n;
  endfunction

  // Non-zero power-up junk that the flush has to clear.
  logic [6:0] h_a = 7'h5a, hf_a = 7'h33;
  logic [6:0] h_b = 7'h2d, hf_b = 7'h4c;
  logic [2:0] flip_a = 3'b000, flip_b = 3'b000;   // corrupts one MISR input pattern

  always @(posedge CLK) begin
    h_a  <= misr_next(h_a, {e2_a, e1_a, e0_a} ^ flip_a);
    hf_a <= h_a;
    h_b  <= misr_next(h_b, {e2_b, e1_b, e0_b} ^ flip_b);
    hf_b <= h_b;
  end
  assign sig_a = hf_a;
  assign sig_b = hf_b;

  // ---------------- scoreboard ----------------
  logic [2:0] e_q[$];      // expected e per busy cycle
  logic [7:0] res_q[$];    // {pass, signature}
  int         done_q[$];   // cycle count at which done rises
  int n_checks = 0;
  int n_pass   = 0;
  bit sel      = 1'b0;     // instance currently exercised
  logic [6:0] last_sig[2] = '{7'h00, 7'h00};
  bit in_done[2]          = '{1'b0, 1'b0};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Reference model: pattern stream straight from the LFSR recurrence, the
  // signature by folding the patterns through the MISR from the all-zero state.
  task automatic push_run(input bit which, input int flip_k, input logic [2:0] flip_m);
    int f, n;
    logic [7:0] l;
    logic [6:0] h, gold;
    logic [2:0] p;
    f    = which ? F_B : F_A;
    n    = which ? N_B : N_A;
    l    = which ? SEED_B : SEED_A;
    gold = which ? GOLD_B : GOLD_A;
    for (int i = 0; i < f; i++) e_q.push_back(3'b111);
    h = 7'h00;
    for (int k = 0; k < n; k++) begin
      p = l[2:0];
      e_q.push_back(p);
      if (k == flip_k) p = p ^ flip_m;
      h = misr_next(h, p);
      l = {l[6:0], ^(l & 8'hB8)};
    end
    e_q.push_back(3'b000);   // DRAIN
    e_q.push_back(3'b000);   // CMP
    res_q.push_back({(h == gold), h});
    done_q.push_back(cyc + 1 + f + n + 2);
    last_sig[which] = h;
  endtask

  // ---------------- monitor ----------------
  logic       mon_busy, mon_done, mon_prev, mon_pass;
  logic [2:0] mon_e;
  logic [6:0] mon_sig;
  logic [7:0] mon_r;
  logic       done_prev_a = 1'b0, done_prev_b = 1'b0;

  always @(negedge CLK) begin
    mon_busy = sel ? busy_b : busy_a;
    mon_done = sel ? done_b : done_a;
    mon_prev = sel ? done_prev_b : done_prev_a;
    mon_pass = sel ? pass_b : pass_a;
    mon_e    = sel ? {e2_b, e1_b, e0_b} : {e2_a, e1_a, e0_a};
    mon_sig  = sel ? signature_b : signature_a;
    if (mon_busy) begin
      if (e_q.size() == 0) fail_now("e_q_underflow");
      else chk("e_pattern", 32'(mon_e), 32'(e_q.pop_front()));
    end
    if (mon_done && !mon_prev) begin
      if (res_q.size() == 0 || done_q.size() == 0) fail_now("unexpected_done");
      else begin
        mon_r = res_q.pop_front();
        chk("signature", 32'(mon_sig), 32'(mon_r[6:0]));
        chk("pass", 32'(mon_pass), 32'(mon_r[7]));
        chk("done_cycle", 32'(cyc), 32'(done_q.pop_front()));
        chk("busy_length", 32'(e_q.size()), 32'd0);
      end
    end
    done_prev_a = done_a;
    done_prev_b = done_b;
  end

  // ---------------- driver tasks ----------------
  function automatic logic get_done(input bit w); return w ? done_b : done_a; endfunction
  function automatic logic get_busy(input bit w); return w ? busy_b : busy_a; endfunction
  function automatic logic get_pass(input bit w); return w ? pass_b : pass_a; endfunction
  function automatic logic [6:0] get_sig(input bit w); return w ? signature_b : signature_a; endfunction

  task automatic set_start(input bit w, input logic v);
    if (w) start_b = v; else start_a = v;
  endtask

  task automatic set_flip(input bit w, input logic [2:0] v);
    if (w) flip_b = v; else flip_a = v;
  endtask

  // One full test. flip_k < 0 means no corrupted pattern; spurious adds a
  // start pulse while busy, which must not change anything.
  task automatic run(input bit which, input int flip_k, input logic [2:0] flip_m, input bit spurious);
    int f, n, t, spur_t;
    bit was_done;
    logic [6:0] prev;
    f        = which ? F_B : F_A;
    n        = which ? N_B : N_A;
    spur_t   = spurious ? $urandom_range(1, f + n + 1) : -1;
    @(negedge CLK);
    sel      = which;
    was_done = in_done[which];
    prev     = last_sig[which];
    push_run(which, flip_k, flip_m);
    set_start(which, 1'b1);
    @(negedge CLK);
    set_start(which, 1'b0);
    t = 1;
    chk("busy_rise", 32'(get_busy(which)), 32'd1);
    if (was_done) begin
      chk("restart_done_low", 32'(get_done(which)), 32'd0);
      chk("restart_pass_low", 32'(get_pass(which)), 32'd0);
      chk("restart_sig_hold", 32'(get_sig(which)), 32'(prev));
    end
    while (!get_done(which) && t < 300) begin
      set_flip(which, (flip_k >= 0 && t == f + flip_k + 1) ? flip_m : 3'b000);
      set_start(which, (t == spur_t) ? 1'b1 : 1'b0);
      @(negedge CLK);
      t++;
    end
    set_flip(which, 3'b000);
    set_start(which, 1'b0);
    if (!get_done(which)) begin
      fail_now("timeout_done");
      in_done[which] = 1'b0;
    end else in_done[which] = 1'b1;
  endtask

  task automatic clear_sb();
    e_q.delete();
    res_q.delete();
    done_q.delete();
  endtask

  task automatic reset_mid_run();
    @(negedge CLK);
    sel = 1'b0;
    push_run(1'b0, -1, 3'b000);
    start_a = 1'b1;
    @(negedge CLK);
    start_a = 1'b0;
    repeat (F_A + 1) @(negedge CLK);   // second RUN cycle
    #1 RST_N = 1'b0;
    clear_sb();
    in_done = '{1'b0, 1'b0};
    #1;
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_done", 32'(done_a), 32'd0);
    chk("rst_e", 32'({e2_a, e1_a, e0_a}), 32'd0);
    chk("rst_pass", 32'(pass_a), 32'd0);
    chk("rst_signature", 32'(signature_a), 32'd0);
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
  endtask

`ifdef MISR_BIST_ABORT_EN
  task automatic abort_mid_run();
    @(negedge CLK);
    sel = 1'b0;
    push_run(1'b0, -1, 3'b000);
    start_a = 1'b1;
    @(negedge CLK);
    start_a = 1'b0;
    repeat (F_A + 1) @(negedge CLK);   // second RUN cycle
    abort_a = 1'b1;
    @(negedge CLK);
    abort_a = 1'b0;
    chk("abort_busy", 32'(busy_a), 32'd0);
    chk("abort_done", 32'(done_a), 32'd0);
    chk("abort_pass", 32'(pass_a), 32'd0);
    chk("abort_e", 32'({e2_a, e1_a, e0_a}), 32'd0);
    clear_sb();
    in_done[0] = 1'b0;
  endtask
`endif

  // ---------------- stimulus ----------------
  initial begin
    int k;
    logic [2:0] m;
    repeat (3) @(negedge CLK);
    chk("reset_busy_a", 32'(busy_a), 32'd0);
    chk("reset_done_a", 32'(done_a), 32'd0);
    chk("reset_pass_a", 32'(pass_a), 32'd0);
    chk("reset_e_a", 32'({e2_a, e1_a, e0_a}), 32'd0);
    chk("reset_sig_a", 32'(signature_a), 32'd0);
    chk("reset_busy_b", 32'(busy_b), 32'd0);
    chk("reset_e_b", 32'({e2_b, e1_b, e0_b}), 32'd0);
    RST_N = 1'b1;
    repeat (2) @(negedge CLK);

    run(1'b0, -1, 3'b000, 1'b1);                  // clean run, start pulsed while busy
    run(1'b0, 3, 3'b001, 1'b0);                   // restart from DONE, last pattern corrupted
    reset_mid_run();
    run(1'b0, -1, 3'b000, 1'b0);                  // full run after reset
    run(1'b1, -1, 3'b000, 1'b1);                  // N_PATTERNS = 1
    run(1'b1, 0, 3'b010, 1'b0);                   // N_PATTERNS = 1, corrupted
    run(1'b1, -1, 3'b000, 1'b0);

    for (int i = 0; i < 6; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge CLK);
      k = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, N_A - 1));
      m = 3'(1 << $urandom_range(0, 2));
      run(1'b0, k, m, 1'($urandom_range(0, 1)));
    end

`ifdef MISR_BIST_ABORT_EN
    abort_mid_run();
    run(1'b0, -1, 3'b000, 1'b0);
`endif

    repeat (2) @(negedge CLK);
    chk("res_q_drained", 32'(res_q.size()), 32'd0);
    chk("e_q_drained", 32'(e_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    fail_now("watchdog");
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
